// File: rtl/chan_req_pkg.sv
// Shared state codes and sizing helpers for the channel request dispatcher.
package chan_req_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_HDR   = 3'd2;
    localparam logic [2:0] ST_ARB   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // RAM blocks for header + payload bytes of one packet.
    function automatic int unsigned blk_need(input int unsigned len, input int unsigned bpw,
                                             input int unsigned blk_bytes);
        return ceil_div(len + bpw, blk_bytes);
    endfunction

endpackage

// File: rtl/chan_req_rr_enc.sv
// Rotating priority encoder: first set bit at or after ptr_i, wrapping at N.
module rr_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 vld_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int W  = $clog2(N);
    localparam int W1 = W + 1;

    logic [W:0] sum;

    // Scan farthest-first so the closest hit to ptr_i is the last assignment.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        sum   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            sum = {1'b0, ptr_i} + W1'(j);
            if (sum >= W1'(N)) sum = sum - W1'(N);
            if (req_i[sum[W-1:0]]) begin
                vld_o = 1'b1;
                idx_o = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/chan_req_rr.sv
// Per-input-port dispatcher: pops a header, picks an output port round-robin,
// runs the req/grant handshake with timeout, then streams header + payload.
module chan_req_rr
    import chan_req_pkg::*;
#(
    parameter int PORTNUM   = 16,
    parameter int DWIDTH    = 32,
    parameter int RAMWIDTH  = 11,
    parameter int LEN_LSB   = 7,
    parameter int LEN_W     = 10,
    parameter int BLK_BYTES = 256,
    parameter int WAIT_TO   = 64,
    parameter int PORT_ID   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_empty,
    output logic                          o_rd_en,
    input  logic [DWIDTH-1:0]             i_data,
    input  logic [PORTNUM-1:0]            i_ready,
    input  logic [PORTNUM*RAMWIDTH-1:0]   i_ramspace,
    output logic [PORTNUM-1:0]            o_req,
    input  logic [PORTNUM-1:0]            i_resp,
    input  logic [PORTNUM-1:0]            i_nresp,
    output logic [$clog2(PORTNUM)-1:0]    o_dst,
    output logic                          o_sop,
    output logic [DWIDTH-1:0]             o_data,
    output logic                          o_data_vld,
    output logic                          o_eop,
    output logic                          o_timeout
);
    localparam int BPW = DWIDTH / 8;
    localparam int PW  = $clog2(PORTNUM);
    localparam int CW  = LEN_W + 1;
    localparam int BW  = RAMWIDTH + 1;
    localparam int WW  = $clog2(WAIT_TO + 1);

    logic [2:0]        state_q, state_d;
    logic [DWIDTH-1:0] hdr_q, hdr_d;
    logic [PW-1:0]     rr_q, rr_d, dst_q, dst_d, dst_nxt;
    logic [CW-1:0]     k_q, k_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;

    logic [LEN_W-1:0]   len;
    logic [CW-1:0]      p_words;
    logic [BW-1:0]      blk;
    logic [PORTNUM-1:0] elig;
    logic               sel_vld;
    logic [PW-1:0]      sel_idx;
    logic               resp_hit, nresp_hit, timeout_hit;

    assign len     = hdr_q[LEN_LSB +: LEN_W];
    assign p_words = CW'(ceil_div(32'(len), BPW));
    assign blk     = BW'(blk_need(32'(len), BPW, BLK_BYTES));

    for (genvar p = 0; p < PORTNUM; p++) begin : g_elig
        assign elig[p] = i_ready[p] && ({1'b0, i_ramspace[p*RAMWIDTH +: RAMWIDTH]} >= blk);
    end

    rr_prio_enc #(.N(PORTNUM)) u_enc (
        .req_i (elig),
        .ptr_i (rr_q),
        .vld_o (sel_vld),
        .idx_o (sel_idx)
    );

    // Only the requested port's grant/refuse bits count.
    assign resp_hit    = i_resp[dst_q];
    assign nresp_hit   = i_nresp[dst_q];
    assign timeout_hit = (state_q == ST_WAIT) && !resp_hit && !nresp_hit &&
                         (wcnt_q == WW'(WAIT_TO - 1));
    assign dst_nxt     = (dst_q == PW'(PORTNUM - 1)) ? '0 : dst_q + 1'b1;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        rr_d    = rr_q;
        dst_d   = dst_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE:  if (!i_empty) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_HDR;
            ST_HDR: begin
                hdr_d   = i_data;
                state_d = ST_ARB;
            end
            ST_ARB: if (sel_vld) begin
                dst_d   = sel_idx;
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_hit) begin
                    k_d     = '0;
                    state_d = ST_SEND;
                end else if (nresp_hit || timeout_hit) begin
                    rr_d    = dst_nxt;
                    state_d = ST_ARB;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (k_q == p_words) begin
                    rr_d    = dst_nxt;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            rr_q    <= PW'(PORT_ID);
            dst_q   <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            rr_q    <= rr_d;
            dst_q   <= dst_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Payload word k is popped in S(k-1) and forwarded straight from the FIFO in Sk.
    assign o_rd_en    = (state_q == ST_FETCH) || ((state_q == ST_SEND) && (k_q < p_words));
    assign o_req      = (state_q == ST_WAIT) ? (PORTNUM'(1) << dst_q) : '0;
    assign o_dst      = dst_q;
    assign o_data_vld = (state_q == ST_SEND);
    assign o_sop      = o_data_vld && (k_q == '0);
    assign o_eop      = o_data_vld && (k_q == p_words);
    assign o_data     = !o_data_vld ? '0 : ((k_q == '0) ? hdr_q : i_data);
    assign o_timeout  = timeout_hit;

endmodule

// File: tb/tb_chan_req_rr.sv
// Directed bench for chan_req_rr: table of single packets, then hand-written
// refuse / timeout / reset-mid-packet sequences.
module tb_chan_req_rr;
    localparam int PN = 16, DW = 32, RW = 11, LL = 7, LW = 10, BB = 256, WT = 64, PID = 3;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_empty = 1'b1;
    logic               o_rd_en;
    logic [DW-1:0]      i_data = '0;
    logic [PN-1:0]      i_ready;
    logic [PN*RW-1:0]   i_ramspace;
    logic [PN-1:0]      o_req, i_resp, i_nresp;
    logic [3:0]         o_dst;
    logic               o_sop, o_data_vld, o_eop, o_timeout;
    logic [DW-1:0]      o_data;

    chan_req_rr #(.PORTNUM(PN), .DWIDTH(DW), .RAMWIDTH(RW), .LEN_LSB(LL), .LEN_W(LW),
                  .BLK_BYTES(BB), .WAIT_TO(WT), .PORT_ID(PID)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_empty(i_empty), .o_rd_en(o_rd_en),
        .i_data(i_data), .i_ready(i_ready), .i_ramspace(i_ramspace), .o_req(o_req),
        .i_resp(i_resp), .i_nresp(i_nresp), .o_dst(o_dst), .o_sop(o_sop),
        .o_data(o_data), .o_data_vld(o_data_vld), .o_eop(o_eop), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic underflow = 1'b0, rd_empty = 1'b0, multi = 1'b0;

    // Ingress FIFO model: word popped at a rd_en edge is on i_data the next cycle.
    always @(posedge i_clk) begin
        if (o_rd_en) begin
            if (fq.size() == 0) underflow <= 1'b1;
            else i_data <= fq.pop_front();
        end
        i_empty <= (fq.size() == 0);
    end

    always @(negedge i_clk) begin
        if (o_rd_en && i_empty) rd_empty <= 1'b1;
        if (!$onehot0(o_req)) multi <= 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_space_all(input int v);
        for (int p = 0; p < PN; p++) i_ramspace[p*RW +: RW] = RW'(v);
    endtask

    task automatic set_space(input int p, input int v);
        i_ramspace[p*RW +: RW] = RW'(v);
    endtask

    task automatic push_pkt(input int len, input int tag);
        logic [DW-1:0] w;
        int np;
        np = (len + 3) / 4;
        w = 32'hC000_0000 | (32'(tag) << 20) | (32'(len) << LL) | 32'(tag & 'h7f);
        fq.push_back(w);
        exp_q.push_back(w);
        for (int k = 1; k <= np; k++) begin
            w = 32'hD000_0000 | (32'(tag) << 16) | 32'(k);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // Wait (bounded) for o_req; lat >= 0 also checks cycles from the FETCH pop.
    task automatic wait_req(input int dst, input int lat);
        int n, f;
        f = -1;
        for (n = 0; n < 200; n++) begin
            if (o_rd_en && f < 0) f = n;
            if (o_req != '0) break;
            @(negedge i_clk);
        end
        chk("req_onehot", o_req, 64'(1) << dst);
        chk("req_dst", o_dst, dst);
        if (lat >= 0) chk("req_latency", n - f, lat);
    endtask

    task automatic grant(input int dst);
        i_resp[dst] = 1'b1;
        @(negedge i_clk);
        i_resp = '0;
    endtask

    task automatic check_send(input int np);
        logic [DW-1:0] w;
        for (int k = 0; k <= np; k++) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("send_word", {o_data_vld, o_sop, o_eop, o_rd_en, (o_req != '0), o_data},
                {1'b1, (k == 0), (k == np), (k < np), 1'b0, w});
            @(negedge i_clk);
        end
        chk("idle_after_send", {o_data_vld, o_sop, o_eop, o_data}, 0);
    endtask

    typedef struct {
        int          len;
        logic [15:0] rdy;
        int          sp;
        int          dst;
        int          np;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int w;
        logic [PN-1:0] anyreq;
        tbl = '{
            '{40,  16'hFFFF, 4, 3, 10},
            '{0,   16'hFFFF, 4, 4, 0},
            '{4,   16'h0100, 1, 8, 1},
            '{5,   16'hFFFF, 1, 9, 2},
            '{252, 16'h0001, 1, 0, 63}
        };
        i_rst_n = 1'b0;
        i_ready = '0;
        i_ramspace = '0;
        i_resp = '0;
        i_nresp = '0;
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", {o_rd_en, o_req, o_dst, o_sop, o_data_vld, o_eop, o_timeout, o_data}, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 5; i++) begin
            i_ready = tbl[i].rdy;
            set_space_all(tbl[i].sp);
            push_pkt(tbl[i].len, i + 1);
            wait_req(tbl[i].dst, 3);
            grant(tbl[i].dst);
            check_send(tbl[i].np);
        end

        // LEN=1000 needs 4 blocks: ports with 3 free stay ineligible.
        i_ready = '1;
        set_space_all(0);
        for (int p = 3; p <= 6; p++) set_space(p, 3);
        push_pkt(1000, 9);
        anyreq = '0;
        repeat (12) begin
            @(negedge i_clk);
            anyreq |= o_req;
        end
        chk("arb_hold_noreq", anyreq, 0);
        set_space(6, 4);
        wait_req(6, -1);

        // Refuse on 6 -> resume scan at 7, skipping ineligible 7 and 8.
        set_space(9, 4);
        i_nresp[6] = 1'b1;
        @(negedge i_clk);
        i_nresp = '0;
        chk("nresp_req_drop", o_req, 0);
        wait_req(9, -1);
        i_resp[6] = 1'b1;
        i_nresp[3] = 1'b1;
        @(negedge i_clk);
        i_resp = '0;
        i_nresp = '0;
        chk("wrong_port_ignored", o_req, 64'(1) << 9);

        w = 2;
        while (!o_timeout && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        chk("timeout_cycle", w, WT);
        chk("timeout_req_held", o_req, 64'(1) << 9);
        @(negedge i_clk);
        chk("timeout_pulse_end", {o_timeout, o_req}, 0);
        wait_req(6, -1);
        grant(6);
        check_send(250);

        // Reset in the middle of SEND.
        set_space_all(4);
        push_pkt(40, 12);
        wait_req(7, 3);
        grant(7);
        repeat (3) @(negedge i_clk);
        chk("pre_reset_s3", {o_data_vld, o_sop, o_eop}, 3'b100);
        i_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {o_rd_en, o_req, o_dst, o_sop, o_data_vld, o_eop, o_timeout, o_data}, 0);
        fq.delete();
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("post_reset_state", dut.state_q, chan_req_pkg::ST_IDLE);
        chk("post_reset_rr", dut.rr_q, PID);
        anyreq = '0;
        repeat (3) begin
            @(negedge i_clk);
            anyreq |= {o_req[PN-1:1], o_rd_en};
        end
        chk("post_reset_quiet", anyreq, 0);

        chk("fifo_underflow", underflow, 0);
        chk("rd_en_while_empty", rd_empty, 0);
        chk("req_multi_hot", multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
